// File: rtl/regfile_read_sequencer.sv
// Read-side sequencer for a bank of tristate registers sharing one 64-bit read bus.
// Accepts one request at a time, drives a one-hot read enable, waits the settle time, then returns the captured word.
module regfile_read_sequencer #(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_W        = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic [NUM_REGS-1:0] read_sel,
    input  logic [63:0]         bus_data,
    output logic                rsp_valid,
    output logic [63:0]         rsp_data,
    output logic                rsp_err,
    input  logic                rsp_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] NUM_REGS_W  = 32'(NUM_REGS);

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   read_sel_q, read_sel_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  addr_ok_s;
    logic [NUM_REGS-1:0]   sel_onehot_s;

    // Ready is the only unregistered output; it must fall with reset, not one edge later.
    assign req_ready = (state_q == IDLE) && reset;

    assign read_sel  = read_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // Address range check and one-hot decode of the requested register
    always_comb begin
        addr_ok_s    = (32'(req_addr) < NUM_REGS_W);
        sel_onehot_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_onehot_s[i] = (32'(req_addr) == 32'(i));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        read_sel_d  = read_sel_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (addr_ok_s) begin
                        read_sel_d = sel_onehot_s;
                        cnt_d      = SETTLE_LOAD;
                        state_d    = DRIVE;
                    end else begin
                        // Nonexistent register: answer immediately, never touch the bus
                        read_sel_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 64'd0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = bus_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    read_sel_d  = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                read_sel_d  = '0;
                rsp_valid_d = 1'b0;
                cnt_d       = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            read_sel_q  <= '0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_sel_q  <= read_sel_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Bench for regfile_read_sequencer: one instance at defaults (32 regs, settle 1) and one with 20 regs, settle 3.
module tb_regfile_read_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;

    logic        req_valid_a;
    logic [4:0]  req_addr_a;
    logic        req_ready_a;
    logic [31:0] read_sel_a;
    logic [63:0] bus_data_a;
    logic        rsp_valid_a;
    logic [63:0] rsp_data_a;
    logic        rsp_err_a;
    logic        rsp_ready_a;

    logic        req_valid_b;
    logic [4:0]  req_addr_b;
    logic        req_ready_b;
    logic [19:0] read_sel_b;
    logic [63:0] bus_data_b;
    logic        rsp_valid_b;
    logic [63:0] rsp_data_b;
    logic        rsp_err_b;
    logic        rsp_ready_b;

    logic        bus_ovr_en;
    logic [63:0] bus_ovr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    regfile_read_sequencer #(.NUM_REGS(32), .ADDR_W(5), .SETTLE_CYCLES(1)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_addr(req_addr_a), .req_ready(req_ready_a),
        .read_sel(read_sel_a), .bus_data(bus_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a), .rsp_ready(rsp_ready_a)
    );

    regfile_read_sequencer #(.NUM_REGS(20), .ADDR_W(5), .SETTLE_CYCLES(3)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(req_ready_b),
        .read_sel(read_sel_b), .bus_data(bus_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .rsp_ready(rsp_ready_b)
    );

    function automatic logic [63:0] bank_val(input int idx);
        logic [63:0] v;
        if (idx == 7)      v = 64'hDEAD_BEEF_0123_4567;
        else if (idx == 0) v = 64'h0000_0000_0000_0001;
        else               v = {32'hC0DE_0000, 32'(idx)};
        return v;
    endfunction

    // Register bank models: the selected register drives the shared bus
    always_comb begin
        bus_data_a = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (read_sel_a[i]) bus_data_a = bank_val(i);
        end
    end

    always_comb begin
        bus_data_b = 64'd0;
        for (int i = 0; i < 20; i++) begin
            if (read_sel_b[i]) bus_data_b = bank_val(i);
        end
        if (bus_ovr_en) bus_data_b = bus_ovr;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits for rsp_valid on the chosen instance, counting edges and read_sel activity
    task automatic wait_rsp(input bit which, output int edges, output int sel_cycles,
                            output bit multi, output bit timed_out);
        logic [31:0] cur_sel;
        logic        cur_v;
        edges = 0; sel_cycles = 0; multi = 1'b0; timed_out = 1'b0;
        forever begin
            cur_sel = which ? 32'(read_sel_b) : read_sel_a;
            cur_v   = which ? rsp_valid_b : rsp_valid_a;
            if (cur_sel != 32'd0) sel_cycles++;
            if ($countones(cur_sel) > 1) multi = 1'b1;
            if (cur_v) break;
            if (edges >= 50) begin
                timed_out = 1'b1;
                break;
            end
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid_a = 1'b1; req_addr_a = 5'd7; rsp_ready_a = 1'b0;
        req_valid_b = 1'b1; req_addr_b = 5'd3; rsp_ready_b = 1'b0;
        step();
        step();
        checks++; if (read_sel_a !== 32'd0) begin errors++; $display("FAIL reset_read_sel: got %h expected 0", read_sel_a); end
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_a); end
        checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_a); end
        checks++; if (rsp_data_a !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_a); end
        checks++; if (rsp_err_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err_a); end
        checks++; if (read_sel_b !== 20'd0 || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL reset_b: sel %h valid %b expected 0/0", read_sel_b, rsp_valid_b); end
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL release_req_ready_a: got %b expected 1", req_ready_a); end
        checks++; if (req_ready_b !== 1'b1) begin errors++; $display("FAIL release_req_ready_b: got %b expected 1", req_ready_b); end
    endtask

    task automatic test_basic_read();
        int edges, sc; bit multi, to; exp_t e;
        rsp_ready_a = 1'b1;
        req_valid_a = 1'b1; req_addr_a = 5'd7;
        sb.push_back('{data: 64'hDEAD_BEEF_0123_4567, err: 1'b0});
        step();
        req_valid_a = 1'b0;
        checks++; if (read_sel_a !== 32'h80) begin errors++; $display("FAIL basic_sel: got %h expected 00000080", read_sel_a); end
        wait_rsp(1'b0, edges, sc, multi, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: no rsp_valid within 50 cycles"); end
        checks++; if (sc != 1 || multi) begin errors++; $display("FAIL basic_sel_cycles: got %0d multi %b expected 1 multi 0", sc, multi); end
        checks++; if (edges != 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", edges); end
        e = sb.pop_front();
        checks++; if (rsp_data_a !== e.data || rsp_err_a !== e.err) begin errors++; $display("FAIL basic_rsp: got %h/%b expected %h/%b", rsp_data_a, rsp_err_a, e.data, e.err); end
        checks++; if (read_sel_a !== 32'd0) begin errors++; $display("FAIL basic_sel_released: got %h expected 0", read_sel_a); end
        step();
        checks++; if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin errors++; $display("FAIL basic_after_hs: ready %b valid %b expected 1/0", req_ready_a, rsp_valid_a); end
    endtask

    task automatic test_backpressure();
        int edges, sc; bit multi, to; exp_t e;
        rsp_ready_a = 1'b0;
        req_valid_a = 1'b1; req_addr_a = 5'd0;
        sb.push_back('{data: 64'h1, err: 1'b0});
        step();
        req_valid_a = 1'b0;
        wait_rsp(1'b0, edges, sc, multi, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: no rsp_valid within 50 cycles"); end
        e = sb.pop_front();
        checks++; if (rsp_data_a !== e.data || rsp_err_a !== e.err) begin errors++; $display("FAIL bp_rsp: got %h/%b expected %h/%b", rsp_data_a, rsp_err_a, e.data, e.err); end
        req_valid_a = 1'b1; req_addr_a = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rsp_valid_a !== 1'b1 || rsp_data_a !== e.data || read_sel_a !== 32'd0 || req_ready_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid %b data %h sel %h ready %b expected 1/%h/0/0", i, rsp_valid_a, rsp_data_a, read_sel_a, req_ready_a, e.data);
            end
        end
        rsp_ready_a = 1'b1;
        checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL bp_ready_before_hs: got %b expected 0", req_ready_a); end
        step();
        checks++; if (rsp_valid_a !== 1'b0 || read_sel_a !== 32'd0 || req_ready_a !== 1'b1) begin errors++; $display("FAIL bp_hs_edge: valid %b sel %h ready %b expected 0/0/1", rsp_valid_a, read_sel_a, req_ready_a); end
        sb.push_back('{data: 64'hDEAD_BEEF_0123_4567, err: 1'b0});
        step();
        req_valid_a = 1'b0;
        checks++; if (read_sel_a !== 32'h80) begin errors++; $display("FAIL bp_next_accept: got %h expected 00000080", read_sel_a); end
        wait_rsp(1'b0, edges, sc, multi, to);
        e = sb.pop_front();
        checks++; if (to || rsp_data_a !== e.data || rsp_err_a !== e.err) begin errors++; $display("FAIL bp_next_rsp: got %h/%b expected %h/%b", rsp_data_a, rsp_err_a, e.data, e.err); end
        step();
    endtask

    task automatic test_out_of_range();
        int edges, sc; bit multi, to; exp_t e;
        logic [4:0] addrs [3] = '{5'd19, 5'd20, 5'd25};
        rsp_ready_b = 1'b1;
        foreach (addrs[k]) begin
            logic ok;
            ok = (addrs[k] < 5'd20);
            req_valid_b = 1'b1; req_addr_b = addrs[k];
            sb.push_back('{data: ok ? bank_val(int'(addrs[k])) : 64'd0, err: !ok});
            step();
            req_valid_b = 1'b0;
            wait_rsp(1'b1, edges, sc, multi, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL oor_timeout_%0d: no rsp_valid", addrs[k]); end
            checks++; if (edges != (ok ? 3 : 0)) begin errors++; $display("FAIL oor_latency_%0d: got %0d expected %0d", addrs[k], edges, ok ? 3 : 0); end
            checks++; if (sc != (ok ? 3 : 0)) begin errors++; $display("FAIL oor_sel_cycles_%0d: got %0d expected %0d", addrs[k], sc, ok ? 3 : 0); end
            checks++; if (rsp_data_b !== e.data || rsp_err_b !== e.err) begin errors++; $display("FAIL oor_rsp_%0d: got %h/%b expected %h/%b", addrs[k], rsp_data_b, rsp_err_b, e.data, e.err); end
            step();
            checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin errors++; $display("FAIL oor_after_hs_%0d: valid %b ready %b expected 0/1", addrs[k], rsp_valid_b, req_ready_b); end
        end
    endtask

    task automatic test_settle_sweep();
        int edges, sc; bit multi, to; exp_t e;
        rsp_ready_b = 1'b1;
        bus_ovr_en = 1'b1; bus_ovr = 64'h1111_2222_3333_4444;
        req_valid_b = 1'b1; req_addr_b = 5'd5;
        sb.push_back('{data: 64'h5555_6666_7777_8888, err: 1'b0});
        step();
        req_valid_b = 1'b0;
        checks++; if (read_sel_b !== 20'h20) begin errors++; $display("FAIL settle_sel: got %h expected 00020", read_sel_b); end
        step();
        bus_ovr = 64'h5555_6666_7777_8888;
        wait_rsp(1'b1, edges, sc, multi, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL settle_timeout: no rsp_valid"); end
        checks++; if (edges + 1 != 3) begin errors++; $display("FAIL settle_latency: got %0d expected 3", edges + 1); end
        checks++; if (sc + 1 != 3 || multi) begin errors++; $display("FAIL settle_sel_cycles: got %0d multi %b expected 3 multi 0", sc + 1, multi); end
        checks++; if (rsp_data_b !== e.data || rsp_err_b !== e.err) begin errors++; $display("FAIL settle_rsp: got %h/%b expected %h/%b", rsp_data_b, rsp_err_b, e.data, e.err); end
        step();
        bus_ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        bit stale;
        rsp_ready_a = 1'b1;
        req_valid_a = 1'b1; req_addr_a = 5'd3;
        step();
        req_valid_a = 1'b0;
        checks++; if (read_sel_a !== 32'h8) begin errors++; $display("FAIL mid_sel_drive: got %h expected 00000008", read_sel_a); end
        reset = 1'b0;
        step();
        checks++; if (read_sel_a !== 32'd0 || rsp_valid_a !== 1'b0 || req_ready_a !== 1'b0) begin errors++; $display("FAIL mid_reset_edge: sel %h valid %b ready %b expected 0/0/0", read_sel_a, rsp_valid_a, req_ready_a); end
        reset = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid_a !== 1'b0 || read_sel_a !== 32'd0) stale = 1'b1;
        end
        checks++; if (stale) begin errors++; $display("FAIL mid_stale: got stale response/select expected none"); end
        checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", req_ready_a); end
    endtask

    initial begin
        reset = 1'b0;
        req_valid_a = 1'b0; req_addr_a = 5'd0; rsp_ready_a = 1'b0;
        req_valid_b = 1'b0; req_addr_b = 5'd0; rsp_ready_b = 1'b0;
        bus_ovr_en = 1'b0; bus_ovr = 64'd0;
        test_reset();
        test_basic_read();
        test_backpressure();
        test_out_of_range();
        test_settle_sweep();
        test_reset_mid_drive();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
